imem_loader: RTL and testbench
==============================

# imem_loader

Parametrised, clocked instruction memory with a built-in program loader. It replaces the combinational, zero-initialised instruction store with a synchronous RAM. A hardware clear sequence runs after reset, a valid/ready word-stream port lets a host or testbench load a program at runtime, and the fetch port has one-cycle latency and flags faults. It sits between the PC register and the decode stage of the MIPS core.

## Interface
Parameters:
- DATA_W, 32, instruction word width in bits.
- DEPTH, 1024, number of words. Must be a power of two and ≥ 2.
- PC_W, 32, width of the byte-addressed PC input.
- Derived (localparam, not overridable): ADDR_W = $clog2(DEPTH).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- load_start  in  1  one-cycle pulse requesting a program load.
- ld_valid  in  1  load word valid.
- ld_data  in  DATA_W  load word.
- ld_last  in  1  marks the final load word; sampled with ld_valid.
- ld_ready  out  1  loader accepts a word.
- ld_count  out  ADDR_W+1  number of words written by the most recent load.
- mem_ready  out  1  block is in RUN; fetches are served.
- fetch_req  in  1  fetch request.
- pc  in  PC_W  byte address of the fetch.
- instr  out  DATA_W  fetched instruction.
- instr_valid  out  1  instr/fault valid this cycle.
- fault  out  1  the fetch was misaligned or out of range.

## Operation
- FSM states: CLEAR, RUN, LOAD.
- Reset: state=CLEAR, clear pointer=0, load pointer=0.
- Reset values of outputs: ld_ready=0, ld_count=0, mem_ready=0, instr=0, instr_valid=0, fault=0.
- CLEAR:
  - Writes 0 to word[ptr] each cycle and increments ptr.
  - After writing word DEPTH-1, goes to RUN.
  - load_start and fetch_req are ignored.
- RUN:
  - mem_ready=1.
  - On fetch_req, word index = pc[ADDR_W+1:2].
  - fault=1 if pc[1:0]≠0 or pc ≥ 4·DEPTH. A faulting fetch returns instr=0 (NOP) with instr_valid=1.
  - load_start moves the FSM to LOAD, resets the load pointer to 0 and sets ld_count=0.
- LOAD:
  - ld_ready=1, mem_ready=0.
  - Each ld_valid&&ld_ready writes ld_data to word[ptr], increments ptr and increments ld_count.
  - If ld_last is set on an accepted word, or the accepted word is at ptr=DEPTH-1, the FSM goes to RUN.
  - Words not rewritten keep their previous contents.
  - fetch_req is ignored.
- Simultaneous fetch_req and load_start in RUN: the fetch is served normally, then LOAD begins.
- Reset asserted mid-LOAD or mid-CLEAR: immediate return to CLEAR, and the full clear reruns after release.
- Address arithmetic: pointers are ADDR_W bits. ld_count is ADDR_W+1 bits so that it can hold DEPTH. The pointer does not wrap within a load because the load terminates at DEPTH-1.

## Timing
- Fetch latency is 1 cycle: fetch_req sampled at edge N gives instr/instr_valid/fault valid after edge N, for one cycle.
- instr_valid=0 in any cycle that does not follow an accepted fetch. instr holds its last value when instr_valid=0.
- CLEAR lasts exactly DEPTH cycles after the first edge with rst_n=1. mem_ready rises after edge DEPTH.
- The RUN→LOAD transition takes 1 cycle. ld_ready goes high on the edge after the load_start pulse.
- LOAD→RUN takes effect on the accepting edge of the last word. A fetch issued on the next edge returns the newly written data.
- Load throughput is one word per cycle. ld_ready does not depend combinationally on ld_valid.

## Structure
- Package imem_pkg holds:
  - state enum imem_state_t {CLEAR, RUN, LOAD};
  - NOP constant (all zeros);
  - default DATA_W/DEPTH values.
- Sub-module imem_ram: single-port synchronous RAM with parameters DATA_W and DEPTH, inputs we/addr/wdata, registered rdata. The FSM ensures a write and a read never happen in the same cycle.
- The top level contains the FSM, pointers, fault logic and output registers.

## Test plan
- Reset release with DEPTH=16: mem_ready=0 for 16 cycles, then 1. Fetching pc=0x3C then returns instr=0, fault=0.
- load_start, then stream 0x20080005, 0x21290001 with ld_last on the second word: ld_count=2. Fetch pc=0 gives 0x20080005 after 1 cycle; fetch pc=4 gives 0x21290001.
- Fetch pc=0x6 (misaligned) and pc=0x40 with DEPTH=16 (out of range): each returns instr_valid=1, fault=1, instr=0.
- Load 16 words without ld_last at DEPTH=16: FSM returns to RUN after word 16, ld_count=16, ld_ready falls. Word 15 reads back correctly.
- Assert rst_n=0 after 3 load words: all outputs reset immediately. The clear reruns, and a fetch at pc=0 then returns 0.
- Assert load_start and fetch_req(pc=4) in the same cycle: the old word at index 1 is returned with instr_valid=1, and ld_ready goes high the next cycle.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory with program loader.
package imem_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        RUN   = 2'd1,
        LOAD  = 2'd2
    } imem_state_t;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_DEPTH  = 1024;

    localparam logic [DEFAULT_DATA_W-1:0] NOP = '0;

endpackage

// File: rtl/imem_ram.sv
// Single-port synchronous RAM; a write cycle leaves the read register untouched.
module imem_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end else begin
            r_rdata <= r_mem[addr];
        end
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/imem_loader.sv
// Instruction memory front end: post-reset clear, streaming program loader and
// one-cycle fetch port with misalignment / range fault detection.
module imem_loader
    import imem_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int PC_W   = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_start,
    input  logic                     ld_valid,
    input  logic [DATA_W-1:0]        ld_data,
    input  logic                     ld_last,
    output logic                     ld_ready,
    output logic [$clog2(DEPTH):0]   ld_count,
    output logic                     mem_ready,
    input  logic                     fetch_req,
    input  logic [PC_W-1:0]          pc,
    output logic [DATA_W-1:0]        instr,
    output logic                     instr_valid,
    output logic                     fault
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    imem_state_t       r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_ld_count;
    logic              r_ld_ready;
    logic              r_mem_ready;
    logic              r_instr_valid;
    logic              r_fault;
    logic [DATA_W-1:0] r_held;

    logic              w_accept;
    logic              w_bad_pc;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_rdata;
    logic [DATA_W-1:0] w_instr;

    assign w_accept = (r_state == LOAD) && ld_valid && r_ld_ready;
    assign w_bad_pc = (pc[1:0] != 2'b00) || ((pc >> (ADDR_W + 2)) != '0);

    // The RAM port is owned by the pointer in CLEAR/LOAD and by the PC in RUN,
    // so a read and a write can never collide.
    always_comb begin
        w_we    = 1'b0;
        w_addr  = r_ptr;
        w_wdata = DATA_W'(NOP);
        case (r_state)
            CLEAR: w_we = 1'b1;
            RUN:   w_addr = pc[ADDR_W+1:2];
            LOAD: begin
                w_we    = w_accept;
                w_wdata = ld_data;
            end
            default: w_we = 1'b0;
        endcase
    end

    imem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (w_we),
        .addr  (w_addr),
        .wdata (w_wdata),
        .rdata (w_rdata)
    );

    // The RAM read register is not reset and may be reused; r_held keeps the
    // last delivered instruction so instr is stable between fetches.
    assign w_instr = r_instr_valid ? (r_fault ? DATA_W'(NOP) : w_rdata) : r_held;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= CLEAR;
            r_ptr         <= '0;
            r_ld_count    <= '0;
            r_ld_ready    <= 1'b0;
            r_mem_ready   <= 1'b0;
            r_instr_valid <= 1'b0;
            r_fault       <= 1'b0;
            r_held        <= '0;
        end else begin
            r_instr_valid <= 1'b0;
            r_fault       <= 1'b0;
            if (r_instr_valid) begin
                r_held <= w_instr;
            end
            case (r_state)
                CLEAR: begin
                    r_ptr <= r_ptr + ADDR_W'(1);
                    if (r_ptr == LAST_IDX) begin
                        r_state     <= RUN;
                        r_ptr       <= '0;
                        r_mem_ready <= 1'b1;
                    end
                end
                RUN: begin
                    if (fetch_req) begin
                        r_instr_valid <= 1'b1;
                        r_fault       <= w_bad_pc;
                    end
                    if (load_start) begin
                        r_state     <= LOAD;
                        r_ptr       <= '0;
                        r_ld_count  <= '0;
                        r_ld_ready  <= 1'b1;
                        r_mem_ready <= 1'b0;
                    end
                end
                LOAD: begin
                    if (w_accept) begin
                        r_ptr      <= r_ptr + ADDR_W'(1);
                        r_ld_count <= r_ld_count + (ADDR_W + 1)'(1);
                        if (ld_last || (r_ptr == LAST_IDX)) begin
                            r_state     <= RUN;
                            r_ld_ready  <= 1'b0;
                            r_mem_ready <= 1'b1;
                        end
                    end
                end
                default: r_state <= CLEAR;
            endcase
        end
    end

    assign ld_ready    = r_ld_ready;
    assign ld_count    = r_ld_count;
    assign mem_ready   = r_mem_ready;
    assign instr       = w_instr;
    assign instr_valid = r_instr_valid;
    assign fault       = r_fault;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader at DEPTH=16: table-driven fetches,
// directed corner sequences and randomized loads against an array model.
module tb_imem_loader;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int PC_W   = 32;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] expInstr;
        logic        expFault;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              load_start;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic [4:0]        ld_count;
    logic              mem_ready;
    logic              fetch_req;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic              fault;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [DEPTH];
    logic [31:0] ldWords [DEPTH];
    vec_t        vecs [8];

    imem_loader #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PC_W   (PC_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_start  (load_start),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .ld_ready    (ld_ready),
        .ld_count    (ld_count),
        .mem_ready   (mem_ready),
        .fetch_req   (fetch_req),
        .pc          (pc),
        .instr       (instr),
        .instr_valid (instr_valid),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL timeout actual=running required=finished");
        $fatal(1, "[TB] simulation timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Expected result of a fetch, computed from the address rules and the model array.
    function automatic vec_t modelFetch(input logic [31:0] a);
        vec_t v;
        v.pc       = a;
        v.expFault = (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
        v.expInstr = v.expFault ? 32'h0 : model[a[5:2]];
        return v;
    endfunction

    // Issue one fetch, check the response, then check that instr holds afterwards.
    task automatic applyStimulus(input vec_t v, input string tag);
        fetch_req = 1'b1;
        pc        = v.pc;
        tick();
        fetch_req = 1'b0;
        checkOutput($sformatf("%s_valid pc=%h", tag, v.pc), 32'(instr_valid), 32'd1);
        checkOutput($sformatf("%s_fault pc=%h", tag, v.pc), 32'(fault), 32'(v.expFault));
        checkOutput($sformatf("%s_instr pc=%h", tag, v.pc), instr, v.expInstr);
        tick();
        checkOutput($sformatf("%s_validlow", tag), 32'(instr_valid), 32'd0);
        checkOutput($sformatf("%s_hold", tag), instr, v.expInstr);
    endtask

    // Stream n words from ldWords; optional load_start pulse, optional ld_last on the final word.
    task automatic doLoad(input int n, input bit doStart, input bit useLast, input bit gaps);
        int k = 0;
        int budget = 200;
        if (doStart) begin
            load_start = 1'b1;
            tick();
            load_start = 1'b0;
            checkOutput("ld_ready_rise", 32'(ld_ready), 32'd1);
            checkOutput("mem_ready_low_in_load", 32'(mem_ready), 32'd0);
            checkOutput("ld_count_cleared", 32'(ld_count), 32'd0);
        end
        while (k < n && budget > 0) begin
            budget--;
            ld_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            ld_data  = ld_valid ? ldWords[k] : $urandom;
            ld_last  = useLast && (k == n - 1);
            if (ld_valid) begin
                checkOutput($sformatf("ld_ready_word%0d", k), 32'(ld_ready), 32'd1);
            end
            tick();
            if (ld_valid) begin
                model[k] = ldWords[k];
                k++;
            end
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        if (budget == 0) begin
            checkOutput("load_budget", 32'(k), 32'(n));
        end
        checkOutput("ld_count_after", 32'(ld_count), 32'(n));
        if (useLast || n == DEPTH) begin
            checkOutput("ld_ready_fall", 32'(ld_ready), 32'd0);
            checkOutput("mem_ready_back", 32'(mem_ready), 32'd1);
        end else begin
            checkOutput("ld_ready_still", 32'(ld_ready), 32'd1);
        end
    endtask

    // Release reset and verify the DEPTH-cycle clear, with fetch/load requests ignored.
    task automatic releaseAndClear();
        rst_n = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            fetch_req  = 1'b1;
            pc         = 32'h0;
            load_start = 1'b1;
            tick();
            checkOutput($sformatf("clear_mem_ready_c%0d", i), 32'(mem_ready), 32'(i == DEPTH));
            checkOutput($sformatf("clear_no_fetch_c%0d", i), 32'(instr_valid), 32'd0);
            checkOutput($sformatf("clear_no_load_c%0d", i), 32'(ld_ready), 32'd0);
        end
        fetch_req  = 1'b0;
        load_start = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ld_ready"}, 32'(ld_ready), 32'd0);
        checkOutput({tag, "_ld_count"}, 32'(ld_count), 32'd0);
        checkOutput({tag, "_mem_ready"}, 32'(mem_ready), 32'd0);
        checkOutput({tag, "_instr"}, instr, 32'd0);
        checkOutput({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
        checkOutput({tag, "_fault"}, 32'(fault), 32'd0);
    endtask

    initial begin
        vec_t v;
        int   n;
        logic [31:0] a;

        load_start = 1'b0;
        ld_valid   = 1'b0;
        ld_data    = '0;
        ld_last    = 1'b0;
        fetch_req  = 1'b0;
        pc         = '0;
        rst_n      = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("reset");
        tick();
        tick();
        checkResetOutputs("reset_held");

        releaseAndClear();
        applyStimulus(modelFetch(32'h3C), "post_clear");

        // Two-word program with ld_last, then a table of fetches over it.
        ldWords[0] = 32'h20080005;
        ldWords[1] = 32'h21290001;
        doLoad(2, 1'b1, 1'b1, 1'b0);
        vecs[0] = '{32'h00000000, 32'h20080005, 1'b0};
        vecs[1] = '{32'h00000004, 32'h21290001, 1'b0};
        vecs[2] = '{32'h00000008, 32'h00000000, 1'b0};
        vecs[3] = '{32'h00000006, 32'h00000000, 1'b1};
        vecs[4] = '{32'h00000040, 32'h00000000, 1'b1};
        vecs[5] = '{32'h0000003C, 32'h00000000, 1'b0};
        vecs[6] = '{32'h00000001, 32'h00000000, 1'b1};
        vecs[7] = '{32'hFFFFFFFC, 32'h00000000, 1'b1};
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i], $sformatf("table%0d", i));
        end

        // Full-depth load without ld_last terminates on the last slot.
        for (int i = 0; i < DEPTH; i++) ldWords[i] = 32'hA5000000 | 32'(i * 17);
        doLoad(DEPTH, 1'b1, 1'b0, 1'b0);
        applyStimulus(modelFetch(32'h3C), "full_word15");
        applyStimulus(modelFetch(32'h00), "full_word0");

        // Fetch and load_start together: old word 1 returned, then LOAD.
        v          = modelFetch(32'h4);
        fetch_req  = 1'b1;
        pc         = 32'h4;
        load_start = 1'b1;
        tick();
        fetch_req  = 1'b0;
        load_start = 1'b0;
        checkOutput("simul_valid", 32'(instr_valid), 32'd1);
        checkOutput("simul_instr", instr, v.expInstr);
        checkOutput("simul_fault", 32'(fault), 32'd0);
        checkOutput("simul_ld_ready", 32'(ld_ready), 32'd1);
        ldWords[0] = 32'h12345678;
        doLoad(1, 1'b0, 1'b1, 1'b0);
        applyStimulus(modelFetch(32'h0), "simul_new0");
        applyStimulus(modelFetch(32'h4), "simul_keep1");

        // Randomized loads with valid gaps, then random fetches against the model.
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < DEPTH; i++) ldWords[i] = $urandom;
            doLoad(n, 1'b1, (n < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b1);
            for (int f = 0; f < 8; f++) begin
                a = 32'($urandom_range(0, 19)) * 4;
                if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(1, 3));
                if ($urandom_range(0, 7) == 0) a = $urandom;
                applyStimulus(modelFetch(a), $sformatf("rand%0d_%0d", it, f));
            end
        end

        // Reset in the middle of a load: outputs drop at once and the clear reruns.
        for (int i = 0; i < DEPTH; i++) ldWords[i] = 32'hDEAD0000 | 32'(i);
        doLoad(3, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        checkResetOutputs("midload_reset");
        tick();
        releaseAndClear();
        applyStimulus(modelFetch(32'h0), "after_reclear0");
        applyStimulus(modelFetch(32'h8), "after_reclear2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
